// File: rtl/symdrv_pkg.sv
// Shared types and sizing helpers for the symbol stream driver.
package symdrv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    STREAM,
    DONE
  } state_t;

  localparam int unsigned SYM_W = 8;

  function automatic int unsigned bytes_per_word(input int unsigned word_w);
    return word_w / SYM_W;
  endfunction

  // Byte index needs at least one bit even for single-byte words.
  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/symdrv_word_buffer.sv
// Single-word holding buffer: stores one input word and steps through its valid bytes.
module symdrv_word_buffer
  import symdrv_pkg::*;
#(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned NB     = WORD_W / SYM_W,
  parameter int unsigned IDX_W  = idx_width(NB),
  parameter int unsigned CNT_W  = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_last,
  input  logic [CNT_W-1:0]  i_bytes,
  input  logic              i_advance,
  output logic              o_full,
  output logic [SYM_W-1:0]  o_byte,
  output logic              o_final_byte,
  output logic              o_last
);

  logic [WORD_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_count;
  logic              r_last;
  logic              r_full;
  logic [CNT_W-1:0]  w_count_in;

  // A zero or out-of-range byte count on the last word means a full word.
  always_comb begin
    w_count_in = CNT_W'(NB);
    if (i_last && (i_bytes != '0) && (i_bytes < CNT_W'(NB))) begin
      w_count_in = i_bytes;
    end
  end

  assign o_full       = r_full;
  assign o_last       = r_last;
  assign o_byte       = r_data[r_idx*SYM_W +: SYM_W];
  assign o_final_byte = ((CNT_W'(r_idx) + CNT_W'(1)) == r_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_idx   <= '0;
      r_count <= w_count_in;
      r_last  <= i_last;
      r_full  <= 1'b1;
    end else if (i_advance) begin
      if (o_final_byte) begin
        r_full <= 1'b0;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/symbol_stream_driver.sv
// Serializes packed input words into one symbol per cycle for the automata kernels.
// Optional SYMDRV_OFFSET_EN adds a per-stream symbol offset counter on sym_offset.
module symbol_stream_driver
  import symdrv_pkg::*;
#(
  parameter int unsigned WORD_W       = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned OFFSET_W     = 32,
  localparam int unsigned NB          = bytes_per_word(WORD_W),
  localparam int unsigned CNT_W       = $clog2(NB + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [CNT_W-1:0]    in_bytes,
  input  logic                hold,
  output logic [SYM_W-1:0]    symbols,
  output logic                run,
  output logic                auto_reset,
  output logic                stream_done,
  output logic [OFFSET_W-1:0] sym_offset
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [SYM_W-1:0] r_last_sym;

  logic             w_advance;
  logic             w_in_ready;
  logic             w_auto_reset;
  logic             w_done;
  logic             w_load;
  logic             w_buf_full;
  logic             w_buf_last;
  logic             w_final;
  logic [SYM_W-1:0] w_byte;

  symdrv_word_buffer #(
    .WORD_W (WORD_W),
    .NB     (NB),
    .IDX_W  (idx_width(NB)),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_data       (in_data),
    .i_last       (in_last),
    .i_bytes      (in_bytes),
    .i_advance    (w_advance),
    .o_full       (w_buf_full),
    .o_byte       (w_byte),
    .o_final_byte (w_final),
    .o_last       (w_buf_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != FLUSH)) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Refill is allowed in the same cycle the final byte of a non-last word leaves,
  // which keeps back-to-back words gap-free.
  always_comb begin
    w_state_nxt  = r_state;
    w_advance    = 1'b0;
    w_in_ready   = 1'b0;
    w_auto_reset = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_auto_reset = 1'b1;
        if (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1)) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_advance  = w_buf_full & ~hold;
        w_in_ready = ~w_buf_full | (w_advance & w_final & ~w_buf_last);
        if (w_advance && w_final && w_buf_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load      = in_valid & w_in_ready;
  assign in_ready    = w_in_ready;
  assign run         = w_advance;
  assign auto_reset  = w_auto_reset;
  assign stream_done = w_done;
  assign symbols     = w_advance ? w_byte : r_last_sym;

  // symbols holds the last emitted byte whenever run is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_sym <= '0;
    end else if (w_advance) begin
      r_last_sym <= w_byte;
    end
  end

`ifdef SYMDRV_OFFSET_EN
  logic [OFFSET_W-1:0] r_offset;

  always_ff @(posedge clk) begin
    if (reset || (r_state == FLUSH)) begin
      r_offset <= '0;
    end else if (w_advance) begin
      r_offset <= r_offset + 1'b1;
    end
  end

  assign sym_offset = r_offset;
`else
  assign sym_offset = '0;
`endif

endmodule
